// File: rtl/ram_arb_pkg.sv
// ============================================================================
// ram_arb_pkg : shared constants and types for the RAM arbiter
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_arb_pkg;

  localparam int N_REQ = 3;
  localparam int ID_W  = $clog2(N_REQ);

  typedef logic [ID_W-1:0] id_t;

  localparam id_t REQ_FETCH = id_t'(0);
  localparam id_t REQ_DATA  = id_t'(1);
  localparam id_t REQ_DEBUG = id_t'(2);

  function automatic id_t next_ptr(input id_t i);
    return (i == id_t'(N_REQ - 1)) ? '0 : id_t'(i + 1'b1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_arb_rr_pick.sv
// ============================================================================
// rr_pick  : combinational round-robin selector, search starts at ptr
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
  import ram_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  id_t              ptr,
  output logic [N_REQ-1:0] gnt,
  output id_t              id,
  output logic             hit
);

  always_comb begin
    gnt = '0;
    id  = '0;
    hit = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!hit && req[j]) begin
        hit = 1'b1;
        id  = id_t'(j);
      end
    end
    if (hit) gnt = N_REQ'(1) << id;
  end

endmodule

`default_nettype wire

// File: rtl/ram_arb.sv
// ============================================================================
// ram_arb  : round-robin arbiter sharing one RAM port among fetch/data/debug
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arb
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ-1:0]              we,
  input  logic [N_REQ-1:0][ADDR_W-1:0]  addr,
  input  logic [N_REQ-1:0][DATA_W-1:0]  wdata,
  output logic [N_REQ-1:0]              gnt,
  output logic [N_REQ-1:0]              rvalid,
  output logic [DATA_W-1:0]             rdata,
  output logic                          ram_en,
  output logic                          ram_we,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [DATA_W-1:0]             ram_wdata,
  input  logic [DATA_W-1:0]             ram_rdata
);

  id_t              r_ptr;
  logic [RD_LAT-1:0] r_pv;
  id_t              r_pid [RD_LAT];

  logic [N_REQ-1:0] w_req;
  logic [N_REQ-1:0] w_gnt;
  id_t              w_id;
  logic             w_any;
  logic             w_rv_hit;

  // Masking requests under reset keeps every RAM drive quiet in that cycle.
  assign w_req = req & {N_REQ{~rst}};

  rr_pick u_pick (
    .req (w_req),
    .ptr (r_ptr),
    .gnt (w_gnt),
    .id  (w_id),
    .hit (w_any)
  );

  assign gnt = w_gnt;

  always_comb begin
    ram_en    = w_any;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (w_any) begin
      ram_we    = we[w_id];
      ram_addr  = addr[w_id];
      ram_wdata = wdata[w_id];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
      r_pv  <= '0;
      for (int s = 0; s < RD_LAT; s++) r_pid[s] <= '0;
    end else begin
      if (w_any) r_ptr <= next_ptr(w_id);
      r_pv[0]  <= w_any & ~we[w_id];
      r_pid[0] <= w_id;
      for (int s = 1; s < RD_LAT; s++) begin
        r_pv[s]  <= r_pv[s-1];
        r_pid[s] <= r_pid[s-1];
      end
    end
  end

  assign w_rv_hit = r_pv[RD_LAT-1] & ~rst;
  assign rvalid   = w_rv_hit ? (N_REQ'(1) << r_pid[RD_LAT-1]) : '0;
  assign rdata    = w_rv_hit ? ram_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_ram_arb.sv
// ============================================================================
// tb_ram_arb : three arbiter instances (RD_LAT 1..3) against a queue model
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_arb;
  import ram_arb_pkg::*;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;
  localparam int N_DUT  = 3;

  typedef struct {
    int         cyc;
    int         id;
    logic [7:0] data;
  } rd_t;

  logic clk = 1'b0;
  logic rst;
  logic [2:0]        req, we;
  logic [2:0][8:0]   addr;
  logic [2:0][7:0]   wdata;

  logic [2:0] gnt_o       [N_DUT];
  logic [2:0] rvalid_o    [N_DUT];
  logic [7:0] rdata_o     [N_DUT];
  logic       ram_en_o    [N_DUT];
  logic       ram_we_o    [N_DUT];
  logic [8:0] ram_addr_o  [N_DUT];
  logic [7:0] ram_wdata_o [N_DUT];
  logic [7:0] ram_rdata_i [N_DUT];

  int   n_chk = 0, n_fail = 0, cyc = 0;
  int   m_ptr, m_gi;
  logic [7:0] shadow [512];
  rd_t  rq [$];
  bit   pend [3];

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int a);
    return (a == 16) ? 8'hA5 : 8'((a * 37 + 11) & 255);
  endfunction

  for (genvar k = 0; k < N_DUT; k++) begin : g_dut
    logic [7:0] mem     [512];
    logic [7:0] rd_pipe [k+1];

    ram_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(k + 1)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .we        (we),
      .addr      (addr),
      .wdata     (wdata),
      .gnt       (gnt_o[k]),
      .rvalid    (rvalid_o[k]),
      .rdata     (rdata_o[k]),
      .ram_en    (ram_en_o[k]),
      .ram_we    (ram_we_o[k]),
      .ram_addr  (ram_addr_o[k]),
      .ram_wdata (ram_wdata_o[k]),
      .ram_rdata (ram_rdata_i[k])
    );

    initial for (int a = 0; a < 512; a++) mem[a] = init_val(a);

    always @(posedge clk) begin
      if (ram_en_o[k] && ram_we_o[k]) mem[ram_addr_o[k]] <= ram_wdata_o[k];
      rd_pipe[0] <= mem[ram_addr_o[k]];
      for (int s = 1; s <= k; s++) rd_pipe[s] <= rd_pipe[s-1];
    end

    assign ram_rdata_i[k] = rd_pipe[k];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Mid-cycle: predict this cycle's grant and returns, compare every instance.
  task automatic sample();
    logic [2:0] eg, ev;
    logic [7:0] ed;
    #4;
    m_gi = -1;
    if (!rst)
      for (int k = 0; k < 3; k++)
        if (m_gi < 0 && req[(m_ptr + k) % 3]) m_gi = (m_ptr + k) % 3;
    eg = (m_gi >= 0) ? (3'b001 << m_gi) : 3'b000;
    for (int d = 0; d < N_DUT; d++) begin
      check($sformatf("gnt_L%0d", d + 1), 32'(gnt_o[d]), 32'(eg));
      check($sformatf("ram_en_L%0d", d + 1), 32'(ram_en_o[d]), 32'(m_gi >= 0));
      check($sformatf("ram_we_L%0d", d + 1), 32'(ram_we_o[d]), 32'(m_gi >= 0 && we[m_gi]));
      check($sformatf("ram_addr_L%0d", d + 1), 32'(ram_addr_o[d]),
            (m_gi >= 0) ? 32'(addr[m_gi]) : 32'd0);
      if (m_gi < 0 || we[m_gi])
        check($sformatf("ram_wdata_L%0d", d + 1), 32'(ram_wdata_o[d]),
              (m_gi >= 0) ? 32'(wdata[m_gi]) : 32'd0);
      ev = 3'b000;
      ed = 8'h00;
      if (!rst)
        foreach (rq[n])
          if (rq[n].cyc == cyc - (d + 1)) begin
            ev = 3'b001 << rq[n].id;
            ed = rq[n].data;
          end
      check($sformatf("rvalid_L%0d", d + 1), 32'(rvalid_o[d]), 32'(ev));
      if (ev != 3'b000 || rst)
        check($sformatf("rdata_L%0d", d + 1), 32'(rdata_o[d]), 32'(ed));
    end
  endtask

  task automatic advance();
    if (rst) begin
      m_ptr = 0;
      rq.delete();
    end else if (m_gi >= 0) begin
      m_ptr = (m_gi + 1) % 3;
      if (we[m_gi]) shadow[addr[m_gi]] = wdata[m_gi];
      else          rq.push_back('{cyc, m_gi, shadow[addr[m_gi]]});
    end
    cyc++;
    while (rq.size() > 0 && rq[0].cyc < cyc - 3) void'(rq.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic put(input int i, input bit w, input logic [8:0] a, input logic [7:0] dv);
    req[i]   = 1'b1;
    we[i]    = w;
    addr[i]  = a;
    wdata[i] = dv;
  endtask

  task automatic idle();
    req = 3'b000;
    we  = 3'b000;
  endtask

  task automatic drain();
    idle();
    for (int n = 0; n < 4; n++) step();
  endtask

  initial begin
    rst   = 1'b1;
    req   = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;
    m_ptr = 0;
    m_gi  = -1;
    for (int a = 0; a < 512; a++) shadow[a] = init_val(a);
    @(posedge clk);
    #1;
    put(0, 0, 9'h001, 8'h00);
    step();
    step();
    rst = 1'b0;

    // Sole fetch read of the preloaded 0xA5 location.
    idle(); put(int'(REQ_FETCH), 0, 9'h010, 8'h00);
    sample(); check("t_fetch_gnt", 32'(gnt_o[0]), 32'h1); advance();
    idle();
    sample(); check("t_fetch_rv", 32'(rvalid_o[0]), 32'h1);
    check("t_fetch_rd", 32'(rdata_o[0]), 32'hA5); advance();
    drain();

    // All three held from reset: strict rotation.
    rst = 1'b1; step(); rst = 1'b0;
    put(0, 0, 9'h001, 8'h00); put(1, 0, 9'h002, 8'h00); put(2, 0, 9'h003, 8'h00);
    for (int n = 0; n < 6; n++) begin
      sample(); check("t_rr_seq", 32'(gnt_o[0]), 32'(3'b001 << (n % 3))); advance();
    end
    drain();

    // Data write then debug read of the same word.
    put(int'(REQ_DATA), 1, 9'h020, 8'h3C); step();
    req[1] = 1'b0; put(int'(REQ_DEBUG), 0, 9'h020, 8'h00); step();
    idle();
    sample(); check("t_raw_rv", 32'(rvalid_o[0]), 32'h4);
    check("t_raw_rd", 32'(rdata_o[0]), 32'h3C); advance();
    drain();

    // Back-to-back fetch reads seen on the RD_LAT=3 instance.
    for (int n = 0; n < 7; n++) begin
      idle();
      if (n < 4) put(0, 0, 9'(n), 8'h00);
      sample();
      if (n >= 3) begin
        check("t_b2b_rv", 32'(rvalid_o[2]), 32'h1);
        check("t_b2b_rd", 32'(rdata_o[2]), 32'(init_val(n - 3)));
      end
      advance();
    end
    drain();

    // Reset one cycle after a read grant discards it; pointer restarts at 0.
    put(0, 0, 9'h005, 8'h00); step();
    idle(); rst = 1'b1; step(); rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      sample(); check("t_rst_rv", 32'(rvalid_o[1]), 32'h0); advance();
    end
    put(0, 0, 9'h006, 8'h00); put(1, 0, 9'h007, 8'h00); put(2, 0, 9'h008, 8'h00);
    sample(); check("t_rst_ptr", 32'(gnt_o[0]), 32'h1); advance();
    drain();

    // Debug withdraws before its turn; fetch and data keep alternating.
    rst = 1'b1; step(); rst = 1'b0;
    put(0, 0, 9'h009, 8'h00); put(1, 0, 9'h00A, 8'h00); put(2, 0, 9'h00B, 8'h00);
    for (int n = 0; n < 6; n++) begin
      if (n == 2) req[2] = 1'b0;
      sample();
      check("t_drop_gnt", 32'(gnt_o[0]), 32'(3'b001 << (n % 2)));
      check("t_drop_rv", 32'(rvalid_o[0][2]), 32'h0);
      advance();
    end
    drain();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3; i++) pend[i] = 1'b0;
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(99) < 2);
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] || (m_gi == i && $urandom_range(1) == 0)) begin
          pend[i] = (m_gi == i) ? 1'b1 : ($urandom_range(99) < 40);
          we[i]    = $urandom_range(1);
          addr[i]  = 9'($urandom_range(17));
          wdata[i] = 8'($urandom);
        end else if (m_gi == i) begin
          pend[i] = 1'b0;
        end else if ($urandom_range(99) < 5) begin
          pend[i] = 1'b0;
        end
        req[i] = pend[i];
      end
      step();
    end
    rst = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ram_arb.md
RAM_ARB -- requirements
Module: ram_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, RAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 8, RAM data width.
REQ-003 SHALL have parameter RD_LAT, default 1, RAM read latency in clk cycles, legal 1..4.
REQ-004 SHALL use the requester count N_REQ = 3 from ram_arb_pkg: index 0 = fetch, 1 = data, 2 = debug.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 req  in  N_REQ  per-requester access request, level.
REQ-008 we  in  N_REQ  per-requester write enable, qualified by req.
REQ-009 addr  in  N_REQ x ADDR_W  per-requester address.
REQ-010 wdata  in  N_REQ x DATA_W  per-requester write data.
REQ-011 gnt  out  N_REQ  one-hot grant pulse; access is issued to RAM in this cycle.
REQ-012 rvalid  out  N_REQ  one-hot read-data-valid pulse.
REQ-013 rdata  out  DATA_W  read data, shared by all requesters, valid when any rvalid is high.
REQ-014 ram_en, ram_we  out  1 each; ram_addr  out  ADDR_W; ram_wdata  out  DATA_W  RAM port drive.
REQ-015 ram_rdata  in  DATA_W  RAM read data, valid RD_LAT cycles after ram_en with ram_we = 0.

Function
REQ-016 SHALL grant at most one requester per cycle; gnt, ram_en, ram_we, ram_addr and ram_wdata SHALL be combinational from the current req vector and the pointer, with no request-to-grant latency.
REQ-017 SHALL arbitrate round-robin: the search starts at pointer ptr; on a grant to index i, ptr becomes (i+1) mod N_REQ at the next edge; with no grant, ptr holds.
REQ-018 Starvation bound: a requester holding req SHALL be granted within N_REQ-1 grants to others.
REQ-019 Requester protocol: req, we, addr and wdata stay stable until the gnt cycle; dropping req before gnt is legal and yields no access.
REQ-020 A requester holding req after its gnt SHALL be treated as a new request; a sole requester SHALL be granted every cycle.
REQ-021 A write SHALL complete in its gnt cycle and produce no rvalid.
REQ-022 A read granted in cycle T SHALL pulse rvalid[i] in cycle T+RD_LAT, with rdata = ram_rdata in that cycle.
REQ-023 In-flight tracking SHALL use an RD_LAT-deep shift pipeline of {valid, id}; back-to-back reads SHALL return in grant order, one per cycle.
REQ-024 rvalid SHALL have no back-pressure; requesters SHALL accept data in the rvalid cycle.
REQ-025 Ordering: accesses SHALL reach the RAM in grant order; a read granted after a write to the same address SHALL return the written data.
REQ-026 Idle outputs: ram_en = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0.

Reset
REQ-027 While rst = 1: gnt = 0, rvalid = 0, rdata = 0, RAM drive = 0, ptr = 0, pipeline valid bits cleared.
REQ-028 Reads in flight when rst asserts SHALL be discarded and produce no rvalid after reset.
REQ-029 The first cycle after rst deasserts SHALL arbitrate normally from ptr = 0.

Structure
REQ-030 ram_arb_pkg SHALL hold N_REQ, the requester index constants (REQ_FETCH, REQ_DATA, REQ_DEBUG) and the id typedef of width $clog2(N_REQ).
REQ-031 The round-robin selector SHALL be a combinational sub-module rr_pick (inputs req and ptr; outputs one-hot gnt and id).
REQ-032 The pipeline and ptr SHALL be the only state in ram_arb.

Verification
REQ-033 Sole fetch read: req = 001, addr0 = 0x10, RAM[0x10] = 0xA5 -> gnt = 001 at T, rvalid = 001 with rdata = 0xA5 at T+1.
REQ-034 All three requesters held for 6 cycles from reset -> grant sequence 0, 1, 2, 0, 1, 2.
REQ-035 Data writes 0x3C to 0x20, then debug reads 0x20 while data drops req -> debug rvalid with rdata = 0x3C.
REQ-036 RD_LAT = 3, fetch reads 0x00..0x03 back-to-back -> four consecutive rvalid[0] pulses from T+3, in order.
REQ-037 rst asserted one cycle after a read grant, RD_LAT = 2 -> no rvalid at any later cycle; ptr = 0 after reset.
REQ-038 Debug drops req before its grant while fetch and data are held -> no debug access, no debug rvalid, rotation continues between fetch and data.
